vc_fifo_bank: RTL and testbench
===============================

Name: vc_fifo_bank

Overview:
- Bank of NUM_VC independent virtual-channel FIFOs. Generalises the single VC0 FIFO to N channels, parametric width and depth, runtime-programmable almost-full/almost-empty thresholds, and per-channel sticky overflow/underflow error.
- Sits between the PCIe QoS traffic-class mapper (write side) and the VC arbiter (read side).
- Each channel has its own read and write strobes and its own status flags. All channels share one clock and one reset.

Parameters:
- BW, 16, data word width in bits.
- DEPTH, 8, entries per channel. Must be a power of two, at least 4.
- NUM_VC, 4, number of virtual channels.
- AW, $clog2(DEPTH), address width. Derived; do not override.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr  in  NUM_VC  per-channel write strobe.
- data_in  in  NUM_VC*BW  flattened write data; channel i uses bits [i*BW +: BW].
- rd  in  NUM_VC  per-channel read strobe.
- af_thresh  in  AW+1  almost-full threshold, shared by all channels.
- ae_thresh  in  AW+1  almost-empty threshold, shared by all channels.
- data_out  out  NUM_VC*BW  flattened read data.
- full  out  NUM_VC  count == DEPTH.
- empty  out  NUM_VC  count == 0.
- almost_full  out  NUM_VC  count >= af_thresh.
- almost_empty  out  NUM_VC  count <= ae_thresh.
- error_output  out  NUM_VC  sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous assert, synchronous-edge release):
  - Per channel: wr_ptr = 0, rd_ptr = 0, count = 0, data_out = 0, error_output = 0.
  - Flags after reset: empty = 1, full = 0, almost_empty = 1 (count 0 <= any threshold), almost_full = (af_thresh == 0).
  - Memory contents are not reset.
- Counter and pointers:
  - count is AW+1 bits, range 0..DEPTH.
  - Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
- Write accepted when wr && (!full || rd): mem[wr_ptr] <= data, wr_ptr++.
- Read accepted when rd && !empty:
  - Default (registered) mode: data_out <= mem[rd_ptr] on the edge; valid the cycle after the strobe (1-cycle latency).
  - rd_ptr++.
- data_out holds its last value whenever no read is accepted.
- Count update: +1 on write only, -1 on read only, unchanged when both are accepted.
- Full with rd && wr together: both accepted, count stays DEPTH, full stays 1.
- Empty with rd && wr together: the write is accepted (count becomes 1); the read is rejected as underflow.
- Overflow (wr && full && !rd): write dropped, memory and pointers unchanged, error_output[i] <= 1.
- Underflow (rd && empty): no pointer change, data_out unchanged, error_output[i] <= 1.
- error_output is sticky until reset.
- Flags are combinational from the registered count and the threshold inputs, so they reflect an operation one edge after its strobe. Threshold changes take effect combinationally.
- Channels are fully independent. No cross-channel arbitration inside this block.
- Reset asserted mid-operation: all state clears immediately; in-flight data is discarded.

Optional Feature:
- Macro: VC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out[i] = mem[rd_ptr] combinationally whenever !empty[i]; 0 when empty.
  - rd acts as "pop"; next word visible in the same cycle after the edge.
  - Read latency is 0.
  - All other rules unchanged.
- Undefined: registered read as above (1-cycle latency).

Decomposition:
- Package vc_fifo_pkg holds:
  - default BW, DEPTH and NUM_VC constants;
  - the clog2 helper function;
  - a typedef for the per-channel status bundle (full, empty, almost_full, almost_empty, error).
- Sub-module vc_fifo_chan: one channel containing memory, pointers, count, flags and error.
- vc_fifo_bank generate-instantiates NUM_VC copies and slices the flattened buses.

Test Plan (BW=16, DEPTH=8, NUM_VC=4, af_thresh=6, ae_thresh=2):
- Reset then idle:
  - all empty=1, almost_empty=1, full=0, almost_full=0, error_output=0, data_out=0.
- Ordering and flags on VC2:
  - Write 0xA000..0xA007 on VC2 → full[2]=1 after 8th edge; almost_full[2]=1 from count 6.
  - Read 8 words → data_out 0xA000..0xA007 in order, 1 cycle after each rd; empty[2]=1 at end.
  - Other VCs' flags unchanged throughout.
- Overflow:
  - VC1 full, wr=1, rd=0, data 0xDEAD → write dropped, error_output[1]=1 and stays 1.
  - Subsequent reads return the original 8 words.
- Underflow:
  - VC3 empty, rd=1 → error_output[3]=1, data_out[3] unchanged.
- Simultaneous rd/wr:
  - VC0 full: count stays 8, no error, next data is correct after wrap-around.
  - VC0 empty: count becomes 1, error_output[0]=1.
- Reset mid-stream:
  - VC0 holds 5 words; assert reset between edges → flags return to reset values immediately, count=0 without waiting for a clock edge.
- With VC_FIFO_FWFT_EN:
  - Write 0x1234 → data_out[0]=0x1234 the cycle after the write, before any rd.

Source files
------------

// File: rtl/vc_fifo_pkg.sv
// rtl/vc_fifo_pkg.sv - shared defaults, clog2 helper and status bundle for the VC FIFO bank
package vc_fifo_pkg;

    localparam int VC_BW_DEF    = 16;
    localparam int VC_DEPTH_DEF = 8;
    localparam int VC_NUM_DEF   = 4;

    function automatic int vc_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic error;
    } vc_status_t;

endpackage

// File: rtl/vc_fifo_chan.sv
// rtl/vc_fifo_chan.sv - one virtual-channel FIFO; VC_FIFO_FWFT_EN selects first-word-fall-through read
module vc_fifo_chan
    import vc_fifo_pkg::*;
#(
    parameter int BW    = VC_BW_DEF,
    parameter int DEPTH = VC_DEPTH_DEF,
    parameter int AW    = vc_clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic [BW-1:0] data_i,
    input  logic [AW:0]   af_thresh_i,
    input  logic [AW:0]   ae_thresh_i,
    output logic [BW-1:0] data_o,
    output vc_status_t    status_o
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          err_q;
    logic          full, empty, wr_ok, rd_ok, fault;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // A full FIFO still takes a write when a read frees the slot on the same edge.
    assign wr_ok = wr_i && (!full || rd_i);
    assign rd_ok = rd_i && !empty;
    assign fault = (wr_i && full && !rd_i) || (rd_i && empty);

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
        else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (fault) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= data_i;
    end

`ifdef VC_FIFO_FWFT_EN
    assign data_o = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [BW-1:0] dout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      dout_q <= '0;
        else if (rd_ok) dout_q <= mem_q[rd_ptr_q];
    end

    assign data_o = dout_q;
`endif

    assign status_o.full         = full;
    assign status_o.empty        = empty;
    assign status_o.almost_full  = (count_q >= af_thresh_i);
    assign status_o.almost_empty = (count_q <= ae_thresh_i);
    assign status_o.error        = err_q;

endmodule

// File: rtl/vc_fifo_bank.sv
// rtl/vc_fifo_bank.sv - NUM_VC independent FIFOs on flattened buses; VC_FIFO_FWFT_EN enables FWFT reads
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int BW     = VC_BW_DEF,
    parameter int DEPTH  = VC_DEPTH_DEF,
    parameter int NUM_VC = VC_NUM_DEF,
    parameter int AW     = vc_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_VC-1:0]    wr,
    input  logic [NUM_VC*BW-1:0] data_in,
    input  logic [NUM_VC-1:0]    rd,
    input  logic [AW:0]          af_thresh,
    input  logic [AW:0]          ae_thresh,
    output logic [NUM_VC*BW-1:0] data_out,
    output logic [NUM_VC-1:0]    full,
    output logic [NUM_VC-1:0]    empty,
    output logic [NUM_VC-1:0]    almost_full,
    output logic [NUM_VC-1:0]    almost_empty,
    output logic [NUM_VC-1:0]    error_output
);

    vc_status_t status [NUM_VC];

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        vc_fifo_chan #(
            .BW    (BW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_chan (
            .clk_i       (clk),
            .rst_i       (reset),
            .wr_i        (wr[i]),
            .rd_i        (rd[i]),
            .data_i      (data_in[i*BW +: BW]),
            .af_thresh_i (af_thresh),
            .ae_thresh_i (ae_thresh),
            .data_o      (data_out[i*BW +: BW]),
            .status_o    (status[i])
        );

        assign full[i]         = status[i].full;
        assign empty[i]        = status[i].empty;
        assign almost_full[i]  = status[i].almost_full;
        assign almost_empty[i] = status[i].almost_empty;
        assign error_output[i] = status[i].error;
    end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// tb/tb_vc_fifo_bank.sv - table vectors plus scoreboard-driven sequences for vc_fifo_bank
module tb_vc_fifo_bank;

    localparam int BW = 16;
    localparam int NV = 4;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    wr = '0, rd = '0;
    logic [63:0]   data_in = '0;
    logic [3:0]    af_thresh = 4'd6, ae_thresh = 4'd2;
    logic [63:0]   data_out;
    logic [3:0]    full, empty, almost_full, almost_empty, error_output;

    vc_fifo_bank dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error_output (error_output)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          vc;
        logic [15:0] d;
    } sb_t;

    typedef struct {
        logic [3:0]  wr, rd;
        logic [63:0] din;
        logic [3:0]  e_full, e_empty, e_af, e_ae, e_err;
        logic [63:0] e_dout;
    } vec_t;

    sb_t         sbq[$];
    int          mcount[NV];
    logic [3:0]  merr;
    logic [15:0] exp_dout[NV];
    int          checks = 0;
    int          fails = 0;
    vec_t        tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] head(input int v);
        for (int i = 0; i < sbq.size(); i++)
            if (sbq[i].vc == v) return sbq[i].d;
        return 16'h0;
    endfunction

    function automatic logic [15:0] pop(input int v);
        logic [15:0] d;
        for (int i = 0; i < sbq.size(); i++)
            if (sbq[i].vc == v) begin
                d = sbq[i].d;
                sbq.delete(i);
                return d;
            end
        return 16'hxxxx;
    endfunction

    task automatic check_all(input string tag);
        logic [3:0]  ef, ee, eaf, eae;
        logic [63:0] ed;
        for (int v = 0; v < NV; v++) begin
            ef[v]  = (mcount[v] == DP);
            ee[v]  = (mcount[v] == 0);
            eaf[v] = (mcount[v] >= int'(af_thresh));
            eae[v] = (mcount[v] <= int'(ae_thresh));
`ifdef VC_FIFO_FWFT_EN
            ed[v*BW +: BW] = (mcount[v] == 0) ? 16'h0 : head(v);
`else
            ed[v*BW +: BW] = exp_dout[v];
`endif
        end
        chk({tag, ".full"}, 64'(full), 64'(ef));
        chk({tag, ".empty"}, 64'(empty), 64'(ee));
        chk({tag, ".almost_full"}, 64'(almost_full), 64'(eaf));
        chk({tag, ".almost_empty"}, 64'(almost_empty), 64'(eae));
        chk({tag, ".error"}, 64'(error_output), 64'(merr));
        chk({tag, ".data_out"}, data_out, ed);
    endtask

    task automatic model_clear();
        sbq.delete();
        merr = '0;
        for (int v = 0; v < NV; v++) begin
            mcount[v]   = 0;
            exp_dout[v] = '0;
        end
    endtask

    task automatic step(input string tag, input logic [3:0] w, input logic [3:0] r, input logic [63:0] din);
        bit fm, em, wok, rok;
        wr = w;
        rd = r;
        data_in = din;
        for (int v = 0; v < NV; v++) begin
            fm  = (mcount[v] == DP);
            em  = (mcount[v] == 0);
            wok = w[v] && (!fm || r[v]);
            rok = r[v] && !em;
            if (rok) begin
                exp_dout[v] = pop(v);
                mcount[v]--;
            end
            if (wok) begin
                sbq.push_back('{v, din[v*BW +: BW]});
                mcount[v]++;
            end
            if ((w[v] && fm && !r[v]) || (r[v] && em)) merr[v] = 1'b1;
        end
        @(posedge clk);
        #1;
        wr = '0;
        rd = '0;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Hand-derived vectors on VC0 plus one VC3 underflow; thresholds 6 / 2.
        tbl[0] = '{4'h0, 4'h0, 64'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 64'h0};
        tbl[1] = '{4'h1, 4'h0, 64'h0111, 4'h0, 4'hE, 4'h0, 4'hF, 4'h0, 64'h0};
        tbl[2] = '{4'h1, 4'h0, 64'h0222, 4'h0, 4'hE, 4'h0, 4'hF, 4'h0, 64'h0};
        tbl[3] = '{4'h1, 4'h0, 64'h0333, 4'h0, 4'hE, 4'h0, 4'hE, 4'h0, 64'h0};
        tbl[4] = '{4'h0, 4'h1, 64'h0, 4'h0, 4'hE, 4'h0, 4'hF, 4'h0, 64'h0111};
        tbl[5] = '{4'h0, 4'h8, 64'h0, 4'h0, 4'hE, 4'h0, 4'hF, 4'h8, 64'h0111};
        tbl[6] = '{4'h1, 4'h1, 64'h0444, 4'h0, 4'hE, 4'h0, 4'hF, 4'h8, 64'h0222};
        tbl[7] = '{4'h0, 4'h1, 64'h0, 4'h0, 4'hE, 4'h0, 4'hF, 4'h8, 64'h0333};
        tbl[8] = '{4'h0, 4'h1, 64'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h8, 64'h0444};

        model_clear();
        #1;
        check_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step("idle", 4'h0, 4'h0, 64'h0);

        for (int i = 0; i < 9; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk($sformatf("tbl%0d.full", i), 64'(full), 64'(tbl[i].e_full));
            chk($sformatf("tbl%0d.empty", i), 64'(empty), 64'(tbl[i].e_empty));
            chk($sformatf("tbl%0d.af", i), 64'(almost_full), 64'(tbl[i].e_af));
            chk($sformatf("tbl%0d.ae", i), 64'(almost_empty), 64'(tbl[i].e_ae));
            chk($sformatf("tbl%0d.err", i), 64'(error_output), 64'(tbl[i].e_err));
`ifndef VC_FIFO_FWFT_EN
            chk($sformatf("tbl%0d.dout", i), data_out, tbl[i].e_dout);
`endif
        end
        pulse_reset("reset_after_tbl");

        for (int i = 0; i < 8; i++) begin
            step("vc2_wr", 4'h4, 4'h0, 64'(16'hA000 + 16'(i)) << 32);
            chk("vc2_af", 64'(almost_full[2]), 64'(i >= 5));
        end
        chk("vc2_full", 64'(full[2]), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step("vc2_rd", 4'h0, 4'h4, 64'h0);
`ifndef VC_FIFO_FWFT_EN
            chk("vc2_order", 64'(data_out[47:32]), 64'(16'hA000 + 16'(i)));
`endif
        end
        chk("vc2_empty_end", 64'(empty[2]), 64'd1);

        for (int i = 0; i < 8; i++)
            step("vc1_fill", 4'h2, 4'h0, 64'(16'h1100 + 16'(i)) << 16);
        step("vc1_ovf", 4'h2, 4'h0, 64'hDEAD << 16);
        chk("vc1_err", 64'(error_output[1]), 64'd1);
        step("vc1_sticky", 4'h0, 4'h0, 64'h0);
        for (int i = 0; i < 8; i++) step("vc1_drain", 4'h0, 4'h2, 64'h0);
        chk("vc1_err_kept", 64'(error_output[1]), 64'd1);

        step("vc3_udf", 4'h0, 4'h8, 64'h0);
        chk("vc3_err", 64'(error_output[3]), 64'd1);

        for (int i = 0; i < 8; i++) step("vc0_fill", 4'h1, 4'h0, 64'(16'h0B00 + 16'(i)));
        step("vc0_full_rw", 4'h1, 4'h1, 64'h0BFF);
        chk("vc0_full_rw_full", 64'(full[0]), 64'd1);
        chk("vc0_full_rw_noerr", 64'(error_output[0]), 64'd0);
        for (int i = 0; i < 8; i++) step("vc0_wrap", 4'h0, 4'h1, 64'h0);
`ifndef VC_FIFO_FWFT_EN
        chk("vc0_wrap_last", 64'(data_out[15:0]), 64'h0BFF);
`endif
        step("vc0_empty_rw", 4'h1, 4'h1, 64'h0C00);
        chk("vc0_empty_rw_err", 64'(error_output[0]), 64'd1);
        chk("vc0_empty_rw_cnt", 64'(empty[0]), 64'd0);
`ifdef VC_FIFO_FWFT_EN
        chk("vc0_fwft", 64'(data_out[15:0]), 64'h0C00);
`endif
        step("vc0_pop", 4'h0, 4'h1, 64'h0);

        for (int i = 0; i < 5; i++) step("vc0_five", 4'h1, 4'h0, 64'(16'h0D00 + 16'(i)));
        pulse_reset("reset_mid");
        check_all("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
